// File: rtl/result_ascii_tx_pkg.sv
// result_ascii_tx_pkg: ASCII constants and FSM state encoding for the result-to-ASCII transmitter.
package result_ascii_tx_pkg;
   localparam logic [7:0] ASCII_ZERO  = 8'h30;
   localparam logic [7:0] ASCII_MINUS = 8'h2D;
   localparam logic [7:0] ASCII_SPACE = 8'h20;
   typedef enum logic [2:0] {S_IDLE, S_DIV, S_SIGN, S_SEND, S_WAIT, S_FIN} state_t;
endpackage

// File: rtl/result_ascii_tx_div10_seq.sv
// div10_seq: restoring divide-by-10, one quotient bit per cycle, done on the 33rd cycle.
module div10_seq (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] dividend,
   output logic [31:0] quot,
   output logic [3:0]  rem,
   output logic        done
);
   logic [5:0] cnt;
   logic       run;
   logic [4:0] trial;
   logic [4:0] diff;
   logic       ge;
   always_comb begin
      trial = {rem, quot[31]};
      ge    = trial >= 5'd10;
      diff  = trial - 5'd10;
      done  = run && cnt == 6'd32;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         run  <= 1'b0;
         cnt  <= 6'd0;
         quot <= 32'd0;
         rem  <= 4'd0;
      end else if (run) begin
         if (cnt == 6'd32) run <= 1'b0;
         else begin
            rem  <= ge ? diff[3:0] : trial[3:0];
            quot <= {quot[30:0], ge};
            cnt  <= cnt + 6'd1;
         end
      end else if (start) begin
         quot <= dividend;
         rem  <= 4'd0;
         cnt  <= 6'd0;
         run  <= 1'b1;
      end
   end
endmodule

// File: rtl/result_ascii_tx.sv
// result_ascii_tx: converts an ALU result to decimal ASCII ([sign] digits TERM) and feeds it byte-wise to a UART TX.
module result_ascii_tx
   import result_ascii_tx_pkg::*;
#(
   parameter int         DW     = 32,
   parameter bit         SIGNED = 1'b1,
   parameter logic [7:0] TERM   = ASCII_SPACE
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [DW-1:0] d_in_ALU,
   input  logic          tx_done,
   output logic [7:0]    d_out,
   output logic          tx_start,
   output logic          busy,
   output logic          done
);
   state_t        state, nxt;
   logic [DW-1:0] mag;
   logic          neg, last, tx_done_q, tx_rise, load;
   logic [3:0]    ndig;
   logic [3:0]    dbuf [10];
   logic [7:0]    byte_n;
   logic [31:0]   div_quot;
   logic [3:0]    div_rem;
   logic          div_done;
   div10_seq u_div (
      .clk      (clk),
      .reset    (reset),
      .start    (state == S_DIV),
      .dividend (mag),
      .quot     (div_quot),
      .rem      (div_rem),
      .done     (div_done)
   );
   assign tx_rise = tx_done & ~tx_done_q;
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         d_out     <= 8'd0;
         tx_start  <= 1'b0;
         tx_done_q <= 1'b0;
         ndig      <= 4'd0;
         neg       <= 1'b0;
         last      <= 1'b0;
         mag       <= '0;
      end else begin
         state     <= nxt;
         tx_done_q <= tx_done;
         tx_start  <= load;
         if (load) d_out <= byte_n;
         if (state == S_IDLE && start) begin
            neg  <= SIGNED && d_in_ALU[DW-1];
            mag  <= (SIGNED && d_in_ALU[DW-1]) ? -d_in_ALU : d_in_ALU;
            ndig <= 4'd0;
            last <= 1'b0;
         end
         if (state == S_DIV && div_done) begin
            ndig <= ndig + 4'd1;
            mag  <= div_quot;
         end
         if (state == S_SEND) begin
            if (ndig != 4'd0) ndig <= ndig - 4'd1;
            else last <= 1'b1;
         end
      end
   end
   always_ff @(posedge clk)
      if (state == S_DIV && div_done) dbuf[ndig] <= div_rem;
   // a tx_done edge arriving while tx_start is still high belongs to no byte of ours
   always_comb begin
      nxt = state;
      unique case (state)
         S_IDLE:  nxt = start ? S_DIV : S_IDLE;
         S_DIV:   nxt = div_done ? (div_quot == 32'd0 ? S_SIGN : S_DIV) : S_DIV;
         S_SIGN:  nxt = neg ? S_WAIT : S_SEND;
         S_SEND:  nxt = S_WAIT;
         S_WAIT:  nxt = (tx_rise && !tx_start) ? (last ? S_FIN : S_SEND) : S_WAIT;
         S_FIN:   nxt = S_IDLE;
         default: nxt = S_IDLE;
      endcase
   end
   always_comb begin
      busy   = state == S_DIV || state == S_SIGN || state == S_SEND || state == S_WAIT;
      done   = state == S_FIN;
      load   = (state == S_SIGN && neg) || state == S_SEND;
      byte_n = state == S_SIGN ? ASCII_MINUS :
               ndig != 4'd0   ? ASCII_ZERO + {4'd0, dbuf[ndig - 4'd1]} : TERM;
   end
endmodule

// File: tb/tb_result_ascii_tx.sv
// tb_result_ascii_tx: signed and unsigned instances driven in parallel, bytes checked against an arithmetic model.
module tb_result_ascii_tx;
   typedef logic [7:0] bq_t[$];
   logic        clk = 1'b0;
   logic        reset, start, hold;
   logic [31:0] d_in;
   logic        tx_pulse [2];
   logic [1:0]  tx_done, tx_start, busy, done;
   logic [7:0]  d_out [2];
   logic [7:0]  bytes [2][16];
   int          nb [2];
   int          ndone [2];
   int          total = 0;
   int          passed = 0;
   always #5 clk = ~clk;
   assign tx_done = {tx_pulse[1] | hold, tx_pulse[0] | hold};
   result_ascii_tx #(.DW(32), .SIGNED(1'b1), .TERM(8'h20)) u_s (
      .clk(clk), .reset(reset), .start(start), .d_in_ALU(d_in), .tx_done(tx_done[0]),
      .d_out(d_out[0]), .tx_start(tx_start[0]), .busy(busy[0]), .done(done[0]));
   result_ascii_tx #(.DW(32), .SIGNED(1'b0), .TERM(8'h20)) u_u (
      .clk(clk), .reset(reset), .start(start), .d_in_ALU(d_in), .tx_done(tx_done[1]),
      .d_out(d_out[1]), .tx_start(tx_start[1]), .busy(busy[1]), .done(done[1]));
   task automatic check(input string tag, input longint got, input longint exp);
      total++;
      if (got !== exp) $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      else passed++;
   endtask
   // UART stand-in: logs every byte at tx_start, answers 20 cycles later with a 1-cycle tx_done
   task automatic tx_model(input int k);
      int tcnt = 0;
      tx_pulse[k] = 1'b0;
      forever begin
         @(posedge clk); #1;
         tx_pulse[k] = 1'b0;
         if (reset) tcnt = 0;
         if (done[k]) ndone[k]++;
         if (tx_start[k]) begin
            if (nb[k] < 16) bytes[k][nb[k]] = d_out[k];
            nb[k]++;
            tcnt = 20;
         end else if (tcnt > 0) begin
            tcnt--;
            if (tcnt == 0) tx_pulse[k] = 1'b1;
         end
      end
   endtask
   initial tx_model(0);
   initial tx_model(1);
   function automatic bq_t model(input logic [31:0] v, input bit sgn);
      bq_t q;
      bit neg = sgn && v[31];
      longint m = longint'(v);
      if (neg) m = 64'd4294967296 - m;
      do begin
         q.push_front(8'(48 + m % 10));
         m = m / 10;
      end while (m != 0);
      if (neg) q.push_front(8'h2D);
      q.push_back(8'h20);
      return q;
   endfunction
   task automatic cycle(input int n);
      repeat (n) begin @(posedge clk); #2; end
   endtask
   task automatic launch(input logic [31:0] v);
      nb[0] = 0; nb[1] = 0; ndone[0] = 0; ndone[1] = 0;
      d_in = v; start = 1'b1;
      cycle(1);
      start = 1'b0; d_in = $urandom;
      check($sformatf("busy_after_start_%0h", v), busy, 2'b11);
   endtask
   task automatic wait_bytes(input int n);
      int t = 0;
      while (nb[0] < n && t < 2000) begin cycle(1); t++; end
      if (t >= 2000) check("timeout_bytes", nb[0], n);
   endtask
   task automatic wait_done();
      int t = 0;
      while ((ndone[0] == 0 || ndone[1] == 0) && t < 4000) begin cycle(1); t++; end
      if (t >= 4000) check("timeout_done", ndone[0] + ndone[1], 2);
      cycle(5);
   endtask
   task automatic compare(input logic [31:0] v);
      for (int k = 0; k < 2; k++) begin
         bq_t e = model(v, k == 0);
         check($sformatf("nbytes_%0h_k%0d", v, k), nb[k], e.size());
         for (int i = 0; i < e.size() && i < 16; i++)
            check($sformatf("byte_%0h_k%0d_%0d", v, k, i), bytes[k][i], e[i]);
         check($sformatf("done_cnt_%0h_k%0d", v, k), ndone[k], 1);
         check($sformatf("busy_end_%0h_k%0d", v, k), busy[k], 0);
      end
   endtask
   task automatic run_val(input logic [31:0] v);
      launch(v);
      wait_done();
      compare(v);
   endtask
   task automatic check_idle(input string tag);
      for (int k = 0; k < 2; k++) begin
         check($sformatf("%s_tx_start_k%0d", tag, k), tx_start[k], 0);
         check($sformatf("%s_busy_k%0d", tag, k), busy[k], 0);
         check($sformatf("%s_done_k%0d", tag, k), done[k], 0);
         check($sformatf("%s_d_out_k%0d", tag, k), d_out[k], 0);
      end
   endtask
   initial begin
      reset = 1'b1; start = 1'b0; hold = 1'b0; d_in = 32'd0;
      nb[0] = 0; nb[1] = 0; ndone[0] = 0; ndone[1] = 0;
      cycle(3);
      check_idle("reset");
      reset = 1'b0;
      cycle(2);
      run_val(32'd0);
      run_val(32'd12345);
      run_val(32'hFFFF_FFFF);
      run_val(32'h8000_0000);
      run_val(32'd9);
      run_val(32'd10);
      for (int i = 0; i < 16; i++) run_val($urandom >> $urandom_range(0, 31));
      // second start during a send is dropped
      launch(32'd99);
      wait_bytes(1);
      d_in = 32'd7; start = 1'b1;
      cycle(1);
      start = 1'b0;
      wait_done();
      cycle(100);
      compare(32'd99);
      // tx_done stuck high: raised in the tx_start cycle, so it must not complete the byte
      launch(32'd42);
      wait_bytes(1);
      hold = 1'b1;
      cycle(50);
      check("stuck_nb_k0", nb[0], 1);
      check("stuck_nb_k1", nb[1], 1);
      hold = 1'b0;
      cycle(1);
      hold = 1'b1;
      cycle(1);
      hold = 1'b0;
      wait_done();
      compare(32'd42);
      // reset while waiting on the second byte
      launch(32'd123);
      wait_bytes(2);
      cycle(3);
      reset = 1'b1;
      cycle(1);
      reset = 1'b0;
      check_idle("abort");
      cycle(30);
      check("abort_no_done_k0", ndone[0], 0);
      run_val(32'd5);
      // reset wins over start in the same cycle
      reset = 1'b1; start = 1'b1; d_in = 32'd9;
      cycle(1);
      reset = 1'b0; start = 1'b0;
      check("rst_start_busy", busy, 2'b00);
      cycle(2);
      check("rst_start_busy_later", busy, 2'b00);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
